// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two requesters.
// Round-robin with a bounded burst allowance, one registered RAM command
// per cycle, and a tag pipeline that steers read data back to its issuer.
module ram_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter int          RAM_LAT   = 1,
  parameter logic [3:0]  BURST_MAX = 4'd8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);

  // Saturating increment of the burst counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + 4'd1;
  endfunction

  logic              last;       // requester granted most recently (1 = req1)
  logic [3:0]        burst_cnt;  // consecutive grants to 'last'
  logic              sel0;
  logic              sel1;
  logic              sel_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_push_p0;
  logic [RAM_LAT:0]  tag_vld_p;
  logic [RAM_LAT:0]  tag_id_p;

  // Arbitration. A burst only continues out of a grant in the previous cycle
  // (burst_cnt != 0); after an idle cycle the pointer alone picks the winner.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (req0 && req1) begin
      if ((burst_cnt != 4'd0) && (burst_cnt < BURST_MAX)) begin
        sel0 = ~last;
        sel1 = last;
      end else begin
        sel0 = last;
        sel1 = ~last;
      end
    end else begin
      sel0 = req0;
      sel1 = req1;
    end
  end

  assign gnt0    = sel0 & sys_rst_n;
  assign gnt1    = sel1 & sys_rst_n;
  assign sel_any = sel0 | sel1;

  // Mux the winning requester's access onto the command path.
  always_comb begin
    sel_we    = sel1 ? we1    : we0;
    sel_addr  = sel1 ? addr1  : addr0;
    sel_wdata = sel1 ? wdata1 : wdata0;
  end

  assign rd_push_p0 = sel_any & ~sel_we;

  // Fairness state: priority pointer and burst length.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last      <= 1'b1;
      burst_cnt <= 4'd0;
    end else if (sel_any) begin
      if (sel1 == last) begin
        burst_cnt <= sat_inc(burst_cnt);
      end else begin
        burst_cnt <= 4'd1;
        last      <= sel1;
      end
    end else begin
      burst_cnt <= 4'd0;
    end
  end

  // ---- stage p0 -> p1: registered RAM command ----
  // Register the granted access as the RAM command; address/data hold when idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      ram_rden <= 1'b0;
    end else if (sel_any) begin
      ram_addr <= sel_addr;
      ram_data <= sel_wdata;
      ram_wren <= sel_we;
      ram_rden <= ~sel_we;
    end else begin
      ram_wren <= 1'b0;
      ram_rden <= 1'b0;
    end
  end

  // ---- stage p1 .. p(1+RAM_LAT): read tag pipeline ----
  // Tag entry 0 lines up with the command register; entry RAM_LAT lines up
  // with the cycle in which ram_q carries that command's data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_vld_p <= '0;
      tag_id_p  <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RAM_LAT-1:0], rd_push_p0};
      tag_id_p  <= {tag_id_p[RAM_LAT-1:0], sel1};
    end
  end

  // ---- stage p(2+RAM_LAT): read return ----
  // Capture ram_q for the tagged requester and pulse its rvalid for one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_vld_p[RAM_LAT] & ~tag_id_p[RAM_LAT];
      rvalid1 <= tag_vld_p[RAM_LAT] &  tag_id_p[RAM_LAT];
      if (tag_vld_p[RAM_LAT] && !tag_id_p[RAM_LAT]) rdata0 <= ram_q;
      if (tag_vld_p[RAM_LAT] &&  tag_id_p[RAM_LAT]) rdata1 <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two queue-driven requesters, a behavioural RAM,
// and a scoreboard that predicts read data and return cycles at grant time.
module tb_ram_arbiter;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int RAM_LAT = 1;

  typedef struct {logic we; logic [7:0] addr; logic [7:0] data;} cmd_t;
  typedef struct {int cyc; logic [7:0] data;} exp_t;
  typedef struct {bit id; int cyc;} gnt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_wren, ram_rden;
  logic [7:0] rdata0, rdata1, ram_addr, ram_data;
  logic [7:0] ram_q = 8'h00;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  cmd_t cmd0[$], cmd1[$];
  exp_t exp0[$], exp1[$];
  gnt_t glog[$];
  logic [7:0] mem[256];
  logic [7:0] shadow[256];

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .BURST_MAX(4'd8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM, one cycle read latency.
  initial for (int i = 0; i < 256; i++) begin
    mem[i]    = 8'(i * 7 + 3);
    shadow[i] = 8'(i * 7 + 3);
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  // Requester drivers: present the head of each command queue until granted.
  initial forever begin
    @(posedge clk);
    #1;
    if (cmd0.size() != 0) begin
      req0 = 1'b1; we0 = cmd0[0].we; addr0 = cmd0[0].addr; wdata0 = cmd0[0].data;
    end else req0 = 1'b0;
    if (cmd1.size() != 0) begin
      req1 = 1'b1; we1 = cmd1[0].we; addr1 = cmd1[0].addr; wdata1 = cmd1[0].data;
    end else req1 = 1'b0;
  end

  // Monitor and scoreboard, sampled on the falling edge.
  logic       pg_valid = 0, pg_we = 0;
  logic [7:0] e_addr = 0, e_data = 0, last_rd0 = 0, last_rd1 = 0;
  always @(negedge clk) begin : mon
    cmd_t c;
    exp_t e;
    if (!rst_n) begin
      chk("rst_outputs", {gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_data,
                          ram_wren, ram_rden}, 64'd0);
      exp0.delete();
      exp1.delete();
      pg_valid = 0; e_addr = 0; e_data = 0; last_rd0 = 0; last_rd1 = 0;
    end else begin
      chk("ram_wren", ram_wren, pg_valid & pg_we);
      chk("ram_rden", ram_rden, pg_valid & ~pg_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_data", ram_data, e_data);
      chk("gnt_excl", gnt0 & gnt1, 0);
      pg_valid = 0;
      if (gnt0) begin
        chk("gnt0_req", req0, 1);
        if (cmd0.size() != 0) begin
          c = cmd0.pop_front();
          if (c.we) shadow[c.addr] = c.data;
          else exp0.push_back('{cyc + RAM_LAT + 2, shadow[c.addr]});
          pg_valid = 1; pg_we = c.we; e_addr = c.addr; e_data = c.data;
          glog.push_back('{1'b0, cyc});
        end
      end
      if (gnt1) begin
        chk("gnt1_req", req1, 1);
        if (cmd1.size() != 0) begin
          c = cmd1.pop_front();
          if (c.we) shadow[c.addr] = c.data;
          else exp1.push_back('{cyc + RAM_LAT + 2, shadow[c.addr]});
          pg_valid = 1; pg_we = c.we; e_addr = c.addr; e_data = c.data;
          glog.push_back('{1'b1, cyc});
        end
      end
      if (rvalid0) begin
        if (exp0.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else begin
          e = exp0.pop_front();
          chk("rvalid0_cycle", cyc, e.cyc);
          chk("rdata0", rdata0, e.data);
        end
        last_rd0 = rdata0;
      end else begin
        chk("rdata0_hold", rdata0, last_rd0);
        if (exp0.size() != 0 && exp0[0].cyc < cyc) begin
          chk("rvalid0_missing", 0, 1);
          void'(exp0.pop_front());
        end
      end
      if (rvalid1) begin
        if (exp1.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else begin
          e = exp1.pop_front();
          chk("rvalid1_cycle", cyc, e.cyc);
          chk("rdata1", rdata1, e.data);
        end
        last_rd1 = rdata1;
      end else begin
        chk("rdata1_hold", rdata1, last_rd1);
        if (exp1.size() != 0 && exp1[0].cyc < cyc) begin
          chk("rvalid1_missing", 0, 1);
          void'(exp1.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #3;
      done = (cmd0.size() == 0 && cmd1.size() == 0 && exp0.size() == 0 && exp1.size() == 0);
    end
    if (!done) chk("drain_timeout", 1, 0);
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single read after reset.
    @(posedge clk); #3;
    t0 = cyc; glog.delete();
    cmd0.push_back('{1'b0, 8'h10, 8'h00});
    drain();
    chk("t1_grants", glog.size(), 1);
    chk("t1_gid", glog[0].id, 0);
    chk("t1_gcyc", glog[0].cyc, t0 + 1);
    chk("t1_rdata", rdata0, 8'(8'h10 * 7 + 3));

    // Write then read, same address.
    @(posedge clk); #3;
    t0 = cyc; glog.delete();
    cmd0.push_back('{1'b1, 8'h20, 8'hA5});
    cmd0.push_back('{1'b0, 8'h20, 8'h00});
    drain();
    chk("t2_gcyc0", glog[0].cyc, t0 + 1);
    chk("t2_gcyc1", glog[1].cyc, t0 + 2);
    chk("t2_rdata", rdata0, 8'hA5);

    // Round-robin from reset: simultaneous first requests, bursts of 8.
    do_reset();
    @(posedge clk); #3;
    t0 = cyc; glog.delete();
    for (int i = 0; i < 24; i++) begin
      cmd0.push_back('{1'b0, 8'(8'h40 + i), 8'h00});
      cmd1.push_back('{1'b0, 8'(8'h80 + i), 8'h00});
    end
    drain();
    chk("t3_grants", glog.size(), 48);
    for (int i = 0; i < 48 && i < glog.size(); i++) begin
      chk($sformatf("t3_gid%0d", i), glog[i].id, (i / 8) % 2);
      chk($sformatf("t3_gcyc%0d", i), glog[i].cyc, t0 + 1 + i);
    end

    // Lone requester: granted every cycle, past the burst limit.
    @(posedge clk); #3;
    t0 = cyc; glog.delete();
    for (int i = 0; i < 20; i++)
      cmd1.push_back('{(i % 3) == 0, 8'(8'hC0 + i), 8'(i + 8'h11)});
    drain();
    chk("t4_grants", glog.size(), 20);
    for (int i = 0; i < 20 && i < glog.size(); i++) begin
      chk($sformatf("t4_gid%0d", i), glog[i].id, 1);
      chk($sformatf("t4_gcyc%0d", i), glog[i].cyc, t0 + 1 + i);
    end

    // Reset with two reads in flight.
    @(posedge clk); #3;
    t0 = cyc; n = glog.size();
    cmd0.push_back('{1'b0, 8'h50, 8'h00});
    cmd0.push_back('{1'b0, 8'h51, 8'h00});
    repeat (3) @(posedge clk);
    #2;
    chk("t5_inflight", glog.size(), n + 2);
    rst_n = 1'b0;
    cmd0.push_back('{1'b0, 8'h31, 8'h00});
    cmd1.push_back('{1'b0, 8'h32, 8'h00});
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain();
    chk("t5_grants", glog.size(), n + 4);
    if (glog.size() >= n + 4) begin
      chk("t5_first_gid", glog[n + 2].id, 0);
      chk("t5_first_gcyc", glog[n + 2].cyc, t0 + 4);
      chk("t5_second_gid", glog[n + 3].id, 1);
    end
    chk("t5_rdata0", rdata0, 8'(8'h31 * 7 + 3));
    chk("t5_rdata1", rdata1, 8'(8'h32 * 7 + 3));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
